// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM encoding
// and the default Data_RAM word-index width.
package lsu_pkg;

  localparam int WORD_ADDR_WIDTH_DEF = 10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: load extraction/extension, store byte/half merge,
// and the illegal-funct3 / misalignment flags for one access.
module load_store_align
  import lsu_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  byte_offset_i,
  input  logic [31:0] word_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_word_o,
  output logic        illegal_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{byte_offset_i, 3'b000} +: 8];
  assign half_sel = byte_offset_i[1] ? word_i[31:16] : word_i[15:0];

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    illegal_o     = 1'b0;
    misaligned_o  = 1'b0;
    load_data_o   = '0;
    merged_word_o = word_i;
    case (funct3_i)
      F3_B: begin
        load_data_o = {{24{byte_sel[7]}}, byte_sel};
        merged_word_o[{byte_offset_i, 3'b000} +: 8] = store_data_i[7:0];
      end
      F3_H: begin
        misaligned_o = byte_offset_i[0];
        load_data_o  = {{16{half_sel[15]}}, half_sel};
        merged_word_o[{byte_offset_i[1], 4'b0000} +: 16] = store_data_i[15:0];
      end
      F3_W: begin
        misaligned_o  = |byte_offset_i;
        load_data_o   = word_i;
        merged_word_o = store_data_i;
      end
      // Unsigned widths exist only for loads.
      F3_BU: begin
        illegal_o   = is_store_i;
        load_data_o = {24'h0, byte_sel};
      end
      F3_HU: begin
        illegal_o    = is_store_i;
        misaligned_o = byte_offset_i[0];
        load_data_o  = {16'h0, half_sel};
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage in front of Data_RAM: one request at a time, registered
// one-cycle RAM enables, read-modify-write for SB/SH, formatted load results.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORD_ADDR_WIDTH = WORD_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       is_store,
  input  logic [2:0]                 funct3,
  input  logic [31:0]                addr,
  input  logic [DATA_WIDTH-1:0]      store_data,
  output logic                       resp_valid,
  output logic                       fault,
  output logic [DATA_WIDTH-1:0]      load_data,
  output logic                       ram_read_enable,
  output logic                       ram_write_enable,
  output logic [WORD_ADDR_WIDTH-1:0] ram_read_address,
  output logic [WORD_ADDR_WIDTH-1:0] ram_write_address,
  output logic [DATA_WIDTH-1:0]      ram_data_in,
  input  logic [DATA_WIDTH-1:0]      ram_data_out
);

  lsu_state_e                 state_q, state_d;
  logic [WORD_ADDR_WIDTH-1:0] widx_q, widx_d;
  logic [1:0]                 off_q, off_d;
  logic [2:0]                 funct3_q, funct3_d;
  logic                       is_store_q, is_store_d;
  logic [DATA_WIDTH-1:0]      store_data_q, store_data_d;
  logic                       fault_q, fault_d;
  logic                       rd_en_q, rd_en_d;
  logic                       wr_en_q, wr_en_d;
  logic                       resp_q, resp_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]      load_data_q, load_data_d;

  logic                       idle;
  logic                       al_is_store;
  logic [2:0]                 al_funct3;
  logic [1:0]                 al_off;
  logic [DATA_WIDTH-1:0]      al_store_data;
  logic [DATA_WIDTH-1:0]      al_load_data;
  logic [DATA_WIDTH-1:0]      al_merged;
  logic                       al_illegal;
  logic                       al_misaligned;
  logic                       out_of_range;
  logic                       accept_fault;

  assign idle = (state_q == ST_IDLE);

  // In IDLE the aligner judges the incoming request; afterwards it works on the latched one.
  assign al_is_store   = idle ? is_store         : is_store_q;
  assign al_funct3     = idle ? funct3           : funct3_q;
  assign al_off        = idle ? addr[1:0]        : off_q;
  assign al_store_data = idle ? store_data       : store_data_q;

  load_store_align u_align (
    .is_store_i    (al_is_store),
    .funct3_i      (al_funct3),
    .byte_offset_i (al_off),
    .word_i        (ram_data_out),
    .store_data_i  (al_store_data),
    .load_data_o   (al_load_data),
    .merged_word_o (al_merged),
    .illegal_o     (al_illegal),
    .misaligned_o  (al_misaligned)
  );

  assign out_of_range = |addr[31:WORD_ADDR_WIDTH+2];
  assign accept_fault = out_of_range | al_illegal | al_misaligned;

  always_comb begin
    state_d      = state_q;
    widx_d       = widx_q;
    off_d        = off_q;
    funct3_d     = funct3_q;
    is_store_d   = is_store_q;
    store_data_d = store_data_q;
    fault_d      = fault_q;
    wdata_d      = wdata_q;
    load_data_d  = load_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          widx_d       = addr[WORD_ADDR_WIDTH+1:2];
          off_d        = addr[1:0];
          funct3_d     = funct3;
          is_store_d   = is_store;
          store_data_d = store_data;
          fault_d      = accept_fault;
          load_data_d  = '0;
          if (accept_fault) begin
            state_d = ST_RESP;
          end else if (is_store && funct3 == F3_W) begin
            wdata_d = store_data;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        // Data_RAM output now holds the word latched on the READ edge.
        if (is_store_q) begin
          wdata_d = al_merged;
          state_d = ST_WRITE;
        end else begin
          load_data_d = al_load_data;
          state_d     = ST_RESP;
        end
      end
      ST_WRITE:   state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // Enables and the response strobe are decoded from the next state and registered.
    rd_en_d = (state_d == ST_READ);
    wr_en_d = (state_d == ST_WRITE);
    resp_d  = (state_d == ST_RESP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      widx_q       <= '0;
      off_q        <= '0;
      funct3_q     <= '0;
      is_store_q   <= 1'b0;
      store_data_q <= '0;
      fault_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      resp_q       <= 1'b0;
      wdata_q      <= '0;
      load_data_q  <= '0;
    end else begin
      widx_q       <= widx_d;
      off_q        <= off_d;
      funct3_q     <= funct3_d;
      is_store_q   <= is_store_d;
      store_data_q <= store_data_d;
      fault_q      <= fault_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      resp_q       <= resp_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
    end
  end

  assign req_ready         = idle;
  assign resp_valid        = resp_q;
  assign fault             = fault_q;
  assign load_data         = load_data_q;
  assign ram_read_enable   = rd_en_q;
  assign ram_write_enable  = wr_en_q;
  assign ram_read_address  = widx_q;
  assign ram_write_address = widx_q;
  assign ram_data_in       = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset and
// back-to-back corner sequences, then random traffic against a word-array model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resp_valid;
  logic        fault;
  logic [31:0] load_data;
  logic        ram_read_enable;
  logic        ram_write_enable;
  logic [9:0]  ram_read_address;
  logic [9:0]  ram_write_address;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .is_store          (is_store),
    .funct3            (funct3),
    .addr              (addr),
    .store_data        (store_data),
    .resp_valid        (resp_valid),
    .fault             (fault),
    .load_data         (load_data),
    .ram_read_enable   (ram_read_enable),
    .ram_write_enable  (ram_write_enable),
    .ram_read_address  (ram_read_address),
    .ram_write_address (ram_write_address),
    .ram_data_in       (ram_data_in),
    .ram_data_out      (ram_data_out)
  );

  // Edge-triggered Data_RAM model with a bench-side preload port.
  logic [31:0] ram [1024];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else begin
      if (ram_write_enable) ram[ram_write_address] <= ram_data_in;
      if (ram_read_enable)  ram_data_out <= ram[ram_read_address];
    end
  end

  // Reference memory: what every word should hold per the architectural rules.
  logic [31:0] ref_mem [16];

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, overlap = 0, acc_cnt = 0, cyc = 0;
  logic [9:0]  last_wa;
  logic [31:0] last_wd;
  int acc_q[$];

  always @(negedge clk) begin
    if (ram_read_enable) rd_cnt++;
    if (ram_write_enable) begin
      wr_cnt++;
      last_wa = ram_write_address;
      last_wd = ram_data_in;
    end
    if (ram_read_enable && ram_write_enable) overlap++;
    if (resp_valid) resp_cnt++;
  end

  always @(posedge clk) begin
    cyc++;
    if (!reset && req_valid && req_ready) begin
      acc_cnt++;
      acc_q.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Architectural model: size/alignment/extension by arithmetic on a word array.
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output bit flt, output logic [31:0] ld,
                       output int lat, output int nrd, output int nwr, output logic [31:0] wd);
    int size, idx, off;
    bit legal;
    logic [31:0] w, mask, v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    flt   = (a >= 32'h1000) || !legal || ((a % size) != 0);
    idx   = int'(a[11:2]);
    off   = int'(a[1:0]);
    ld = '0; wd = '0; nrd = 0; nwr = 0;
    if (flt) begin
      lat = 1;
    end else begin
      w = ref_mem[idx];
      if (!st) begin
        lat  = 3;
        nrd  = 1;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        v    = (w >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
        ld = v;
      end else begin
        wd = w;
        for (int b = 0; b < size; b++) wd[8*(off+b) +: 8] = d[8*b +: 8];
        ref_mem[idx] = wd;
        nwr = 1;
        nrd = (size < 4) ? 1 : 0;
        lat = (size < 4) ? 4 : 2;
      end
    end
  endtask

  task automatic run_op(input string name, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input bit eflt,
                        input logic [31:0] eld, input int elat, input int enrd,
                        input int enwr, input logic [31:0] ewd);
    int k, rd0, wr0;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({name, " ready"}, 32'(req_ready), 32'd1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    #1;
    is_store = st; funct3 = f3; addr = a; store_data = d; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (resp_valid) break;
    end
    check({name, " latency"}, 32'(k), 32'(elat));
    check({name, " fault"}, 32'(fault), 32'(eflt));
    check({name, " load_data"}, load_data, eld);
    check({name, " read pulses"}, 32'(rd_cnt - rd0), 32'(enrd));
    check({name, " write pulses"}, 32'(wr_cnt - wr0), 32'(enwr));
    if (enwr != 0) begin
      check({name, " write addr"}, 32'(last_wa), 32'(a[11:2]));
      check({name, " write data"}, last_wd, ewd);
    end
  endtask

  typedef struct {
    string       name;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    bit          flt;
    logic [31:0] ld;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wd;
  } vec_t;

  function automatic vec_t mk(string n, bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] d,
                              bit flt, logic [31:0] ld, int lat, int nrd, int nwr, logic [31:0] wd);
    vec_t v;
    v = '{n, st, f3, a, d, flt, ld, lat, nrd, nwr, wd};
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    bit mflt;
    logic [31:0] mld, mwd, ra, rd;
    logic [2:0] rf;
    bit rs;
    int mlat, mrd, mwr, a0, r0, w0, n, mism;
    logic [2:0] ld_f3 [5];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    reset = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; store_data = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ref_mem[i] = (i == 0) ? 32'h2222_2222 : (i == 1) ? 32'h0 : $urandom;
      pre_we = 1'b1; pre_addr = 10'(i); pre_data = ref_mem[i];
    end
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset fault", 32'(fault), 32'd0);
    check("reset load_data", load_data, 32'd0);
    check("reset enables", {30'd0, ram_read_enable, ram_write_enable}, 32'd0);
    check("reset address", 32'(ram_read_address), 32'd0);

    tbl.push_back(mk("SW 0x004",   1, 3'd2, 32'h004, 32'h80F07F01, 0, 32'h0, 2, 0, 1, 32'h80F07F01));
    tbl.push_back(mk("LB 0x007",   0, 3'd0, 32'h007, 32'h0, 0, 32'hFFFFFF80, 3, 1, 0, 32'h0));
    tbl.push_back(mk("LBU 0x007",  0, 3'd4, 32'h007, 32'h0, 0, 32'h00000080, 3, 1, 0, 32'h0));
    tbl.push_back(mk("LH 0x006",   0, 3'd1, 32'h006, 32'h0, 0, 32'hFFFF80F0, 3, 1, 0, 32'h0));
    tbl.push_back(mk("LHU 0x006",  0, 3'd5, 32'h006, 32'h0, 0, 32'h000080F0, 3, 1, 0, 32'h0));
    tbl.push_back(mk("LB 0x004",   0, 3'd0, 32'h004, 32'h0, 0, 32'h00000001, 3, 1, 0, 32'h0));
    tbl.push_back(mk("SB 0x001",   1, 3'd0, 32'h001, 32'h000000AB, 0, 32'h0, 4, 1, 1, 32'h2222AB22));
    tbl.push_back(mk("LW 0x000",   0, 3'd2, 32'h000, 32'h0, 0, 32'h2222AB22, 3, 1, 0, 32'h0));
    tbl.push_back(mk("LH 0x003",   0, 3'd1, 32'h003, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("SW 0x002",   1, 3'd2, 32'h002, 32'hDEADBEEF, 1, 32'h0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("LW 0x1000",  0, 3'd2, 32'h1000, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("L f3=011",   0, 3'd3, 32'h000, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("SH 0x006",   1, 3'd1, 32'h006, 32'h1234ABCD, 0, 32'h0, 4, 1, 1, 32'hABCD7F01));
    tbl.push_back(mk("LW 0x004",   0, 3'd2, 32'h004, 32'h0, 0, 32'hABCD7F01, 3, 1, 0, 32'h0));
    tbl.push_back(mk("LH 0x002",   0, 3'd1, 32'h002, 32'h0, 0, 32'h00002222, 3, 1, 0, 32'h0));
    tbl.push_back(mk("S f3=100",   1, 3'd4, 32'h000, 32'h55, 1, 32'h0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("LBU 0x005",  0, 3'd4, 32'h005, 32'h0, 0, 32'h0000007F, 3, 1, 0, 32'h0));
    tbl.push_back(mk("LB hi addr", 0, 3'd0, 32'hFFFFFFFC, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0));

    foreach (tbl[i]) begin
      model(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].d, mflt, mld, mlat, mrd, mwr, mwd);
      run_op(tbl[i].name, tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].d, tbl[i].flt,
             tbl[i].ld, tbl[i].lat, tbl[i].nrd, tbl[i].nwr, tbl[i].wd);
    end

    // Reset while an SB sits in CAPTURE: the write must be abandoned silently.
    @(negedge clk);
    #1;
    w0 = wr_cnt; r0 = resp_cnt;
    is_store = 1'b1; funct3 = 3'd0; addr = 32'h014; store_data = 32'h000000CC; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst outputs", {28'd0, resp_valid, fault, ram_read_enable, ram_write_enable}, 32'd0);
    check("rst load_data", load_data, 32'd0);
    check("rst data_in", ram_data_in, 32'd0);
    check("rst address", 32'(ram_write_address), 32'd0);
    check("rst write pulses", 32'(wr_cnt - w0), 32'd0);
    check("rst resp pulses", 32'(resp_cnt - r0), 32'd0);
    model(1'b0, 3'd2, 32'h014, 32'h0, mflt, mld, mlat, mrd, mwr, mwd);
    run_op("LW after rst", 1'b0, 3'd2, 32'h014, 32'h0, mflt, mld, mlat, mrd, mwr, mwd);

    // req_valid held high: one acceptance per IDLE visit, spaced latency+1 apart.
    @(negedge clk);
    #1;
    acc_q.delete();
    a0 = acc_cnt; r0 = resp_cnt;
    is_store = 1'b0; funct3 = 3'd2; addr = 32'h000; req_valid = 1'b1;
    repeat (14) @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (8) @(negedge clk);
    n = acc_cnt - a0;
    check("hold accepts", 32'(n), 32'd4);
    check("hold responses", 32'(resp_cnt - r0), 32'(n));
    for (int i = 1; i < acc_q.size(); i++)
      check("hold spacing", 32'(acc_q[i] - acc_q[i-1]), 32'd4);

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) rf = 3'($urandom_range(0, 7));
      else if (rs)                   rf = 3'($urandom_range(0, 2));
      else                           rf = ld_f3[$urandom_range(0, 4)];
      ra = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 63));
      rd = $urandom;
      model(rs, rf, ra, rd, mflt, mld, mlat, mrd, mwr, mwd);
      run_op($sformatf("rand%0d", i), rs, rf, ra, rd, mflt, mld, mlat, mrd, mwr, mwd);
    end

    mism = 0;
    for (int i = 0; i < 16; i++) if (ram[i] !== ref_mem[i]) mism++;
    check("final memory", 32'(mism), 32'd0);
    check("enable overlap", 32'(overlap), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
